// File: rtl/connector_pkg.sv
// rtl/connector_pkg.sv - shared widths, uop/exception types and packer FSM states for the trace connector
package connector_pkg;

`ifdef TE_ARCH64
  localparam int unsigned XLEN = 64;
`else
  localparam int unsigned XLEN = 32;
`endif
  localparam int unsigned ITYPE_LEN   = 4;
  localparam int unsigned PRIV_LEN    = 2;
  localparam int unsigned IRETIRE_LEN = 32;

  typedef enum logic [ITYPE_LEN-1:0] {
    STD  = 4'd0,
    EXC  = 4'd1,
    INT  = 4'd2,
    ERET = 4'd3,
    NTB  = 4'd4,
    TB   = 4'd5,
    UC   = 4'd8,
    IC   = 4'd9,
    UJ   = 4'd10,
    IJ   = 4'd11,
    CRS  = 4'd12,
    RET  = 4'd13,
    OUJ  = 4'd14,
    OIJ  = 4'd15
  } itype_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    itype_e              itype;
    logic                compressed;
    logic [PRIV_LEN-1:0] priv;
  } uop_entry_s;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exc_info_s;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

endpackage

// File: rtl/te_uop_block_packer.sv
// rtl/te_uop_block_packer.sv - packs popped uops into E-Trace ingress blocks behind a valid/ready output
module te_uop_block_packer
  import connector_pkg::*;
#(
  parameter int unsigned CNT_MAX = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fifo_empty_i,
  input  uop_entry_s             uop_i,
  input  exc_info_s              exc_i,
  output logic                   fifo_pop_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic                   ilastsize_o,
  output logic [ITYPE_LEN-1:0]   itype_o,
  output logic [XLEN-1:0]        iaddr_o,
  output logic [PRIV_LEN-1:0]    priv_o,
  output logic [XLEN-1:0]        cause_o,
  output logic [XLEN-1:0]        tval_o
);

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic [XLEN-1:0]        iaddr;
    logic [ITYPE_LEN-1:0]   itype;
    logic                   ilastsize;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        cause;
    logic [XLEN-1:0]        tval;
  } blk_s;

  localparam logic [IRETIRE_LEN-1:0] CNT_LIM = IRETIRE_LEN'(CNT_MAX - 1);

  logic [0:0]             state_q, state_d;
  logic [XLEN-1:0]        iaddr_q, iaddr_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;
  logic [IRETIRE_LEN-1:0] count_q, count_d;
  logic                   last_size_q, last_size_d;
  logic                   pend_vld_q, pend_vld_d;
  blk_s                   pend_q, pend_d;
  logic                   out_vld_q, out_vld_d;
  blk_s                   out_q, out_d;

  logic                   out_free;
  logic                   pop;
  logic                   u_std;
  logic                   u_exc;
  logic                   u_size;
  logic [IRETIRE_LEN-1:0] u_hw;
  logic                   close_vld;
  logic                   new_vld;
  blk_s                   close_blk;
  blk_s                   new_blk;
  logic                   unused_valid;

  assign unused_valid = uop_i.valid;

  assign out_free = !out_vld_q || ready_i;
  assign pop      = !fifo_empty_i && out_free;
  assign u_std    = (uop_i.itype == STD);
  assign u_exc    = (uop_i.itype == EXC) || (uop_i.itype == INT);
  assign u_size   = !uop_i.compressed;
  assign u_hw     = u_size ? IRETIRE_LEN'(2) : IRETIRE_LEN'(1);

  // close_blk is the open block cut short by a privilege change; new_blk is the block completed by this uop.
  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    priv_d      = priv_q;
    count_d     = count_q;
    last_size_d = last_size_q;
    close_vld   = 1'b0;
    close_blk   = '0;
    new_vld     = 1'b0;
    new_blk     = '0;
    if (pop) begin
      new_blk.itype     = uop_i.itype;
      new_blk.ilastsize = u_size;
      if (u_exc) begin
        new_blk.cause = exc_i.cause;
        new_blk.tval  = exc_i.tval;
      end
      if (state_q == COUNT && uop_i.priv == priv_q) begin
        count_d         = count_q + u_hw;
        last_size_d     = u_size;
        new_blk.iretire = count_d;
        new_blk.iaddr   = iaddr_q;
        new_blk.priv    = priv_q;
        if (!u_std) begin
          new_vld = 1'b1;
          state_d = IDLE;
        end else if (count_d >= CNT_LIM) begin
          new_vld       = 1'b1;
          new_blk.itype = STD;
          state_d       = IDLE;
        end
      end else begin
        if (state_q == COUNT) begin
          close_vld           = 1'b1;
          close_blk.iretire   = count_q;
          close_blk.iaddr     = iaddr_q;
          close_blk.itype     = STD;
          close_blk.ilastsize = last_size_q;
          close_blk.priv      = priv_q;
        end
        iaddr_d         = uop_i.pc;
        priv_d          = uop_i.priv;
        count_d         = u_hw;
        last_size_d     = u_size;
        new_blk.iretire = u_hw;
        new_blk.iaddr   = uop_i.pc;
        new_blk.priv    = uop_i.priv;
        if (!u_std) begin
          new_vld = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = COUNT;
        end
      end
    end
  end

  // Blocks leave in order pending, close, new; at most two exist in any cycle, so one pending slot suffices.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (out_free) begin
      out_vld_d = 1'b0;
      if (pend_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = pend_q;
        pend_vld_d = close_vld || new_vld;
        pend_d     = close_vld ? close_blk : new_blk;
      end else if (close_vld) begin
        out_vld_d  = 1'b1;
        out_d      = close_blk;
        pend_vld_d = new_vld;
        pend_d     = new_blk;
      end else if (new_vld) begin
        out_vld_d  = 1'b1;
        out_d      = new_blk;
        pend_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      iaddr_q     <= '0;
      priv_q      <= '0;
      count_q     <= '0;
      last_size_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      iaddr_q     <= iaddr_d;
      priv_q      <= priv_d;
      count_q     <= count_d;
      last_size_q <= last_size_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
    end
  end

  assign fifo_pop_o  = pop;
  assign valid_o     = out_vld_q;
  assign iretire_o   = out_q.iretire;
  assign ilastsize_o = out_q.ilastsize;
  assign itype_o     = out_q.itype;
  assign iaddr_o     = out_q.iaddr;
  assign priv_o      = out_q.priv;
  assign cause_o     = out_q.cause;
  assign tval_o      = out_q.tval;

endmodule

// File: tb/tb_te_uop_block_packer.sv
// tb/tb_te_uop_block_packer.sv - directed and randomized checks of te_uop_block_packer against a block-list model
module tb_te_uop_block_packer;
  import connector_pkg::*;

  localparam int CNT_MAX = 8;
  localparam int BW = IRETIRE_LEN + 3 * XLEN + ITYPE_LEN + 1 + PRIV_LEN;

  typedef struct {
    uop_entry_s u;
    exc_info_s  e;
  } ent_t;

  typedef struct {
    logic [IRETIRE_LEN-1:0] iret;
    logic [XLEN-1:0]        iaddr;
    logic [ITYPE_LEN-1:0]   itype;
    logic                   ilast;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        cause;
    logic [XLEN-1:0]        tval;
    int                     cyc;
  } blk_t;

  logic                   clk;
  logic                   rst_n;
  logic                   fifo_empty;
  uop_entry_s             uop;
  exc_info_s              exc;
  logic                   fifo_pop;
  logic                   valid;
  logic                   ready;
  logic [IRETIRE_LEN-1:0] iretire;
  logic                   ilastsize;
  logic [ITYPE_LEN-1:0]   itype;
  logic [XLEN-1:0]        iaddr;
  logic [PRIV_LEN-1:0]    priv;
  logic [XLEN-1:0]        cause;
  logic [XLEN-1:0]        tval;

  te_uop_block_packer #(.CNT_MAX(CNT_MAX)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_empty_i (fifo_empty),
    .uop_i        (uop),
    .exc_i        (exc),
    .fifo_pop_o   (fifo_pop),
    .valid_o      (valid),
    .ready_i      (ready),
    .iretire_o    (iretire),
    .ilastsize_o  (ilastsize),
    .itype_o      (itype),
    .iaddr_o      (iaddr),
    .priv_o       (priv),
    .cause_o      (cause),
    .tval_o       (tval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int pop_total = 0;
  int pop_cyc_last = 0;
  bit pop_seen = 0;
  bit rand_ready = 0;
  bit held = 0;
  logic [BW-1:0] prev_vec;

  ent_t fq[$];
  blk_t exp_q[$];
  blk_t got[$];

  bit                     m_open = 0;
  logic [XLEN-1:0]        m_addr;
  logic [PRIV_LEN-1:0]    m_priv;
  int                     m_cnt;
  logic                   m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference: a block is the run of uops since the last close; it closes on priv change (before the uop),
  // on a non-STD uop, or when its halfword count reaches CNT_MAX-1.
  task automatic model_pop(input uop_entry_s u, input exc_info_s e);
    blk_t b;
    if (m_open && u.priv != m_priv) begin
      b = '{iret: IRETIRE_LEN'(m_cnt), iaddr: m_addr, itype: 4'd0, ilast: m_last, priv: m_priv,
            cause: '0, tval: '0, cyc: 0};
      exp_q.push_back(b);
      m_open = 0;
    end
    if (!m_open) begin
      m_open = 1;
      m_addr = u.pc;
      m_priv = u.priv;
      m_cnt  = 0;
    end
    m_cnt  = m_cnt + (u.compressed ? 1 : 2);
    m_last = !u.compressed;
    if (u.itype != STD || m_cnt >= CNT_MAX - 1) begin
      b.iret  = IRETIRE_LEN'(m_cnt);
      b.iaddr = m_addr;
      b.itype = u.itype;
      b.ilast = m_last;
      b.priv  = m_priv;
      b.cause = (u.itype == EXC || u.itype == INT) ? e.cause : '0;
      b.tval  = (u.itype == EXC || u.itype == INT) ? e.tval : '0;
      b.cyc   = 0;
      exp_q.push_back(b);
      m_open = 0;
    end
  endtask

  initial begin
    blk_t e;
    blk_t g;
    logic [BW-1:0] vec;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        pop_seen = 0;
        held     = 0;
      end else begin
        vec = {iretire, iaddr, itype, ilastsize, priv, cause, tval};
        chk("pop_rule", fifo_pop, !fifo_empty && !(valid && !ready));
        if (held) begin
          chk("hold_valid", valid, 1'b1);
          n_cmp++;
          if (vec !== prev_vec) begin
            n_err++;
            $display("FAIL hold_fields: got %h expected %h (cycle %0d)", vec, prev_vec, cyc_n);
          end
        end
        held     = valid && !ready;
        prev_vec = vec;
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_block: got iaddr 0x%0h iretire %0d, expected no block (cycle %0d)",
                     iaddr, iretire, cyc_n);
          end else begin
            e = exp_q.pop_front();
            chk("blk_iretire", iretire, e.iret);
            chk("blk_iaddr", iaddr, e.iaddr);
            chk("blk_itype", itype, e.itype);
            chk("blk_ilastsize", ilastsize, e.ilast);
            chk("blk_priv", priv, e.priv);
            chk("blk_cause", cause, e.cause);
            chk("blk_tval", tval, e.tval);
          end
          g = '{iret: iretire, iaddr: iaddr, itype: itype, ilast: ilastsize, priv: priv,
                cause: cause, tval: tval, cyc: cyc_n};
          got.push_back(g);
        end
        pop_seen = 0;
        if (fifo_pop && !fifo_empty && fq.size() != 0) begin
          pop_total++;
          pop_cyc_last = cyc_n;
          pop_seen = 1;
          model_pop(fq[0].u, fq[0].e);
        end
      end
    end
  end

  task automatic drive_head();
    fifo_empty = (fq.size() == 0);
    if (fq.size() != 0) begin
      uop = fq[0].u;
      exc = fq[0].e;
    end else begin
      uop.pc   = $urandom;
      exc.tval = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen && fq.size() != 0) fq.delete(0);
    pop_seen = 0;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    drive_head();
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input int it, input bit c, input int pr,
                      input logic [XLEN-1:0] ca, input logic [XLEN-1:0] tv);
    ent_t en;
    en.u.valid      = 1'b1;
    en.u.pc         = pc;
    en.u.itype      = itype_e'(it);
    en.u.compressed = c;
    en.u.priv       = PRIV_LEN'(pr);
    en.e.cause      = ca;
    en.e.tval       = tv;
    fq.push_back(en);
  endtask

  task automatic run_until(input string name, input int n, input int max_cyc);
    int k;
    k = 0;
    while (got.size() < n && k < max_cyc) begin
      tick();
      k++;
    end
    chk(name, got.size() >= n, 1'b1);
  endtask

  initial begin
    int p0;
    int pushed;
    int cur_priv;
    logic [XLEN-1:0] pc;
    int it;
    int itlist[12];
    itlist = '{1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14};
    rst_n = 1'b0;
    ready = 1'b1;
    uop   = '0;
    exc   = '0;
    drive_head();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", valid, 1'b0);
    chk("reset_pop", fifo_pop, 1'b0);
    chk("reset_iretire", iretire, '0);
    chk("reset_iaddr", iaddr, '0);
    chk("reset_cause_tval", {cause, tval}, '0);
    rst_n = 1'b1;

    // three 4-byte STD uops then a taken branch
    got.delete();
    push('h100, 0, 0, 3, 0, 0);
    push('h104, 0, 0, 3, 0, 0);
    push('h108, 0, 0, 3, 0, 0);
    push('h10C, 5, 0, 3, 'h77, 'h88);
    drive_head();
    run_until("t1_timeout", 1, 30);
    if (got.size() >= 1) begin
      chk("t1_iaddr", got[0].iaddr, 'h100);
      chk("t1_iretire", got[0].iret, 8);
      chk("t1_itype", got[0].itype, 5);
      chk("t1_ilastsize", got[0].ilast, 1);
      chk("t1_cause", got[0].cause, 0);
    end

    // single compressed exception: one-cycle latency
    got.delete();
    push('h200, 1, 1, 3, 2, 'hDEAD);
    drive_head();
    run_until("t2_timeout", 1, 20);
    if (got.size() >= 1) begin
      chk("t2_latency", got[0].cyc - pop_cyc_last, 1);
      chk("t2_iretire", got[0].iret, 1);
      chk("t2_itype", got[0].itype, 1);
      chk("t2_ilastsize", got[0].ilast, 0);
      chk("t2_cause", got[0].cause, 2);
      chk("t2_tval", got[0].tval, 'hDEAD);
    end

    // privilege change closes the open block
    got.delete();
    push('h300, 0, 0, 0, 0, 0);
    push('h304, 0, 0, 0, 0, 0);
    push('h308, 0, 0, 3, 0, 0);
    push('h30C, 13, 0, 3, 0, 0);
    drive_head();
    run_until("t3_timeout", 2, 30);
    if (got.size() >= 2) begin
      chk("t3_b1_itype", got[0].itype, 0);
      chk("t3_b1_iretire", got[0].iret, 4);
      chk("t3_b1_priv", got[0].priv, 0);
      chk("t3_b2_iretire", got[1].iret, 4);
      chk("t3_b2_itype", got[1].itype, 13);
      chk("t3_b2_priv", got[1].priv, 3);
    end

    // back-pressure: held block stalls popping for five cycles
    got.delete();
    ready = 1'b0;
    push('h600, 1, 0, 3, 5, 6);
    push('h604, 0, 0, 3, 0, 0);
    push('h608, 0, 0, 3, 0, 0);
    push('h60C, 0, 1, 3, 0, 0);
    push('h610, 13, 0, 3, 0, 0);
    drive_head();
    tick();
    p0 = pop_total;
    repeat (5) tick();
    chk("t4_no_pop", pop_total - p0, 0);
    chk("t4_valid_held", valid, 1'b1);
    ready = 1'b1;
    tick();
    chk("t4_resume_pop", pop_total - p0, 1);
    run_until("t4_timeout", 2, 30);

    // CNT_MAX limit: ten 4-byte STD uops
    got.delete();
    for (int i = 0; i < 10; i++) push(XLEN'('h400 + 4 * i), 0, 0, 0, 0, 0);
    drive_head();
    run_until("t5_timeout", 2, 40);
    repeat (10) tick();
    chk("t5_block_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("t5_b1_iretire", got[0].iret, 8);
      chk("t5_b1_iaddr", got[0].iaddr, 'h400);
      chk("t5_b2_iretire", got[1].iret, 8);
      chk("t5_b2_iaddr", got[1].iaddr, 'h410);
    end

    // reset with an open block of count 6
    push('h428, 0, 0, 0, 0, 0);
    drive_head();
    repeat (4) tick();
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    m_open = 0;
    drive_head();
    #1;
    chk("t6_reset_valid", valid, 1'b0);
    chk("t6_reset_iretire", iretire, '0);
    tick();
    tick();
    rst_n = 1'b1;
    got.delete();
    push('h500, 0, 0, 1, 0, 0);
    push('h504, 5, 0, 1, 0, 0);
    drive_head();
    run_until("t6_timeout", 1, 20);
    if (got.size() >= 1) begin
      chk("t6_iaddr", got[0].iaddr, 'h500);
      chk("t6_iretire", got[0].iret, 4);
    end

    // randomized traffic with random back-pressure and FIFO gaps
    rand_ready = 1;
    pushed = 0;
    cur_priv = 0;
    pc = 'h1000;
    for (int c = 0; c < 3000 && pushed < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 6) begin
        if ($urandom_range(0, 7) == 0) cur_priv = $urandom_range(0, 3);
        it = ($urandom_range(0, 9) < 6) ? 0 : itlist[$urandom_range(0, 11)];
        push(pc, it, 1'($urandom_range(0, 1)), cur_priv, $urandom, $urandom);
        pc = pc + 4;
        pushed++;
        drive_head();
      end
      tick();
    end
    rand_ready = 0;
    ready = 1'b1;
    push(pc, 2, 0, cur_priv, 'h8000_0007, 'h1234);
    drive_head();
    for (int c = 0; c < 300 && (fq.size() != 0 || exp_q.size() != 0 || valid); c++) tick();
    repeat (2) tick();
    chk("drain_fifo_empty", fq.size(), 0);
    chk("drain_model_empty", exp_q.size(), 0);
    chk("drain_valid_low", valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
